mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Load/store responder for a multicycle CPU port. It owns a word-wide
//             RAM with byte-lane writes and acknowledges each access after a
//             fixed number of wait states. Bad accesses are flagged on AddrErr.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [1:0]  Size,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ack,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         c_ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAT    = 4'(LATENCY);

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 0..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("mem_responder: DEPTH_WORDS must be a power of 2 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] data_q;
  logic [31:0] dout_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic                w_acc_wr;
  logic [31:0]         w_acc_addr;
  logic [1:0]          w_acc_size;
  logic [31:0]         w_acc_data;
  logic [c_ADDR_W-1:0] w_idx;
  logic [1:0]          w_lane;
  logic                w_err;
  logic                w_commit;
  logic                w_ram_we;
  logic [31:0]         w_word;
  logic [31:0]         w_shift;
  logic [31:0]         w_rdata;
  logic [31:0]         w_wdata;
  logic [3:0]          w_be;

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields must be used instead of the not-yet-latched copy.
  assign w_acc_wr   = (state_q == S_IDLE) ? Wr      : wr_q;
  assign w_acc_addr = (state_q == S_IDLE) ? Address : addr_q;
  assign w_acc_size = (state_q == S_IDLE) ? Size    : size_q;
  assign w_acc_data = (state_q == S_IDLE) ? Datain  : data_q;

  assign w_idx  = w_acc_addr[c_ADDR_W+1:2];
  assign w_lane = w_acc_addr[1:0];
  assign w_err  = (w_acc_size == 2'b11)
               || (w_acc_size == 2'b01 && w_acc_addr[0])
               || (w_acc_size == 2'b10 && w_acc_addr[1:0] != 2'b00)
               || (|w_acc_addr[31:c_ADDR_W+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          cnt_d   = c_LAT;
          state_d = (c_LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_commit = (state_d == S_RESP) && (state_q != S_RESP);
  assign w_ram_we = w_commit && Reset && w_acc_wr && !w_err;

  assign w_word  = mem_q[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_rdata = w_word;
    w_wdata = w_acc_data;
    w_be    = 4'b0000;
    case (w_acc_size)
      2'b00: begin
        w_rdata = {24'b0, w_shift[7:0]};
        w_wdata = {4{w_acc_data[7:0]}};
        w_be    = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_rdata = {16'b0, w_shift[15:0]};
        w_wdata = {2{w_acc_data[15:0]}};
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_be    = 4'b1111;
      end
      default: begin
        w_be    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      data_q  <= 32'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && Req) begin
        wr_q   <= Wr;
        addr_q <= Address;
        size_q <= Size;
        data_q <= Datain;
      end
      if (w_commit) begin
        err_q <= w_err;
        if (w_err) begin
          dout_q <= 32'd0;
        end else if (!w_acc_wr) begin
          dout_q <= w_rdata;
        end
      end
    end
  end

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge Clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign Dataout = dout_q;
  assign Ack     = (state_q == S_RESP);
  assign Busy    = (state_q != S_IDLE);
  assign AddrErr = (state_q == S_RESP) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Directed vector bench for mem_responder (LATENCY=2 and LATENCY=0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] din;
    logic        chk;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr;
  logic [31:0] addr, din, dout;
  logic [1:0]  size;
  logic        ack, busy, aerr;
  logic        zreq, zwr;
  logic [31:0] zaddr, zdin, zdout;
  logic [1:0]  zsize;
  logic        zack, zbusy, zaerr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
    .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Address(addr), .Size(size),
    .Datain(din), .Dataout(dout), .Ack(ack), .Busy(busy), .AddrErr(aerr)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .Req(zreq), .Wr(zwr), .Address(zaddr), .Size(zsize),
    .Datain(zdin), .Dataout(zdout), .Ack(zack), .Busy(zbusy), .AddrErr(zaerr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input vec_t v);
    if (!sel) begin
      req = r; wr = v.wr; addr = v.addr; size = v.size; din = v.din;
    end else begin
      zreq = r; zwr = v.wr; zaddr = v.addr; zsize = v.size; zdin = v.din;
    end
  endtask

  task automatic wait_ack(input bit sel, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if ((sel ? zack : ack) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic access(input bit sel, input vec_t v, input string nm);
    int n;
    bit got;
    @(negedge clk);
    drive(sel, 1'b1, v);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({nm, " busy"}, {31'b0, sel ? zbusy : busy}, 32'd1);
      if ((sel ? zack : ack) === 1'b1) got = 1'b1;
    end
    chk({nm, " latency"}, got ? n : 32'hFFFF_FFFF, sel ? 32'd1 : 32'd3);
    if (got) begin
      chk({nm, " addrerr"}, {31'b0, sel ? zaerr : aerr}, {31'b0, v.err});
      if (v.chk) chk({nm, " dataout"}, sel ? zdout : dout, v.exp);
    end
    drive(sel, 1'b0, v);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   n;
    int   acks;
    bit   got;

    rst_n = 1'b0;
    v = '{1'b0, 32'h0, SZ_W, 32'h0, 1'b0, 32'h0, 1'b0};
    drive(1'b0, 1'b1, v);
    drive(1'b1, 1'b0, v);
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset addrerr", {31'b0, aerr}, 32'd0);
    chk("reset dataout", dout, 32'd0);
    chk("reset dataout z", zdout, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("dataout before ack", dout, 32'd0);

    //            wr    addr          size  din           chk   exp           err
    tbl.push_back('{1'b0, 32'h0000_0000, SZ_W, 32'h0,          1'b0, 32'h0,          1'b0});
    tbl.push_back('{1'b1, 32'h0000_0008, SZ_W, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 32'h0000_0009, SZ_B, 32'h0,          1'b1, 32'h0000_00BE, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_000A, SZ_H, 32'h0,          1'b1, 32'h0000_DEAD, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0008, SZ_W, 32'h1122_3344, 1'b1, 32'h0000_DEAD, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_000B, SZ_B, 32'hFFFF_FF5A, 1'b1, 32'h0000_DEAD, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0008, SZ_W, 32'h0,          1'b1, 32'h5A22_3344, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0000, SZ_W, 32'hCAFE_F00D, 1'b1, 32'h5A22_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0003, SZ_H, 32'h0,          1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b1, 32'h0000_0002, SZ_W, 32'hFFFF_FFFF, 1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b1, 32'h0000_0000, SZ_R, 32'hFFFF_FFFF, 1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, SZ_W, 32'h0,          1'b1, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0100, SZ_W, 32'hFFFF_FFFF, 1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b1, 32'h0000_0101, SZ_B, 32'h0000_00AA, 1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, SZ_W, 32'h0,          1'b1, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0004, SZ_W, 32'h0,          1'b1, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0006, SZ_H, 32'hFFFF_BEEF, 1'b1, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0004, SZ_B, 32'h0000_0012, 1'b1, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0004, SZ_W, 32'h0,          1'b1, 32'hBEEF_0012, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0004, SZ_H, 32'h0,          1'b1, 32'h0000_0012, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0007, SZ_B, 32'h0,          1'b1, 32'h0000_00BE, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_00FC, SZ_W, 32'h8765_4321, 1'b1, 32'h0000_00BE, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_00FE, SZ_B, 32'h0,          1'b1, 32'h0000_0065, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_00FC, SZ_W, 32'h0,          1'b1, 32'h8765_4321, 1'b0});
    tbl.push_back('{1'b0, 32'h1000_0000, SZ_W, 32'h0,          1'b1, 32'h0,          1'b1});
    tbl.push_back('{1'b1, 32'h0000_0010, SZ_W, 32'h0102_0304, 1'b1, 32'h0,          1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      access(1'b0, tbl[i], $sformatf("vec%0d", i));
    end

    // Req held across Ack: next accept happens right after the idle gap cycle,
    // and changing fields after the accept must not matter.
    @(negedge clk);
    v = '{1'b0, 32'h0000_0100, SZ_W, 32'h0, 1'b0, 32'h0, 1'b0};
    drive(1'b0, 1'b1, v);
    wait_ack(1'b0, n, got);
    chk("held first latency", got ? n : 32'hFFFF_FFFF, 32'd3);
    chk("held first addrerr", {31'b0, aerr}, 32'd1);
    addr = 32'h0000_0008;
    @(negedge clk);
    chk("held gap busy", {31'b0, busy}, 32'd0);
    chk("held gap ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    addr = 32'h0000_0000;
    wait_ack(1'b0, n, got);
    chk("held second latency", got ? n : 32'hFFFF_FFFF, 32'd2);
    chk("held second addrerr", {31'b0, aerr}, 32'd0);
    chk("held second dataout", dout, 32'h5A22_3344);
    req = 1'b0;

    // Reset during WAIT, then reset on the commit edge: no Ack, no write.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      v = '{1'b1, 32'h0000_0010, SZ_W, 32'h7777_7777, 1'b0, 32'h0, 1'b0};
      drive(1'b0, 1'b1, v);
      repeat (k) @(negedge clk);
      rst_n = 1'b0;
      req   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("abort%0d busy", k), {31'b0, busy}, 32'd0);
      chk($sformatf("abort%0d dataout", k), dout, 32'd0);
      acks = 0;
      repeat (6) begin
        @(negedge clk);
        if (ack === 1'b1) acks++;
      end
      chk($sformatf("abort%0d no ack", k), acks, 32'd0);
      access(1'b0, '{1'b0, 32'h0000_0010, SZ_W, 32'h0, 1'b1, 32'h0102_0304, 1'b0},
             $sformatf("abort%0d readback", k));
    end

    // Zero wait-state instance.
    access(1'b1, '{1'b1, 32'h0000_0020, SZ_W, 32'hA5A5_C3C3, 1'b1, 32'h0,          1'b0}, "z store");
    access(1'b1, '{1'b0, 32'h0000_0020, SZ_W, 32'h0,          1'b1, 32'hA5A5_C3C3, 1'b0}, "z load w");
    access(1'b1, '{1'b0, 32'h0000_0022, SZ_H, 32'h0,          1'b1, 32'h0000_A5A5, 1'b0}, "z load h");
    access(1'b1, '{1'b0, 32'h0000_0021, SZ_H, 32'h0,          1'b1, 32'h0,          1'b1}, "z misaligned");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
